store_sequence_checker: RTL
===========================

// Module: store_sequence_checker
// PURPOSE
//  Synthesizable, parametrised monitor on the core's data-memory store port (mem_write, alu_result as address, write_data).
//  Checks the stores against a programmable expected sequence of (addr,data) pairs, skipping stores to a scratch window.
//  Reports pass, fail or timeout with a fail code and the offending store captured; sits beside ricsV_top in benches or on FPGA.
// PARAMETERS
//  ADDR_W      32    store address width
//  DATA_W      32    store data width
//  NUM_EXP     8     max expected-store table depth (>=1)
//  IDX_W       $clog2(NUM_EXP+1)  index/length width (localparam, not overridable)
//  TIMEOUT_CYC 4096  cycles in RUN before timeout fail; 0 = watchdog disabled
//  TMO_W       32    watchdog counter width
// PORTS
//  clk        in   1       core clock, rising edge
//  rst        in   1       async active-low reset
//  exp_we     in   1       write expected-table entry (IDLE only)
//  exp_idx    in   IDX_W   table entry index, 0..NUM_EXP-1
//  exp_addr   in   ADDR_W  expected store address
//  exp_data   in   DATA_W  expected store data
//  exp_len    in   IDX_W   number of entries to check; latched on start
//  ign_base   in   ADDR_W  ignore-window base
//  ign_mask   in   ADDR_W  ignore-window mask; store ignored if (addr & ign_mask)==(ign_base & ign_mask)
//  ign_en     in   1       enable ignore window
//  start      in   1       1-cycle pulse: IDLE -> RUN
//  clear      in   1       any state -> IDLE, keeps table contents
//  mem_write  in   1       store strobe from controller
//  st_addr    in   ADDR_W  store address (datapath alu_result)
//  st_data    in   DATA_W  store data (datapath write_data)
//  busy       out  1       state==RUN
//  done       out  1       state is PASS or FAIL
//  pass       out  1       state==PASS
//  fail_code  out  2       0 none, 1 data/addr mismatch, 2 timeout, 3 bad length
//  match_cnt  out  IDX_W   stores matched so far
//  ign_cnt    out  16      stores ignored (saturating at 16'hFFFF)
//  bad_addr   out  ADDR_W  address of first mismatching store
//  bad_data   out  DATA_W  data of first mismatching store
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, table entries 0, watchdog 0, latched length 0.
//  FSM states: IDLE, RUN, PASS, FAIL. PASS/FAIL hold until clear or reset.
//  IDLE: exp_we writes table[exp_idx] next edge; exp_idx>=NUM_EXP is dropped. Stores are not checked.
//  start in IDLE: latch exp_len. If exp_len==0 or >NUM_EXP -> FAIL code 3. Else RUN; match_cnt, ign_cnt, watchdog zeroed.
//  start outside IDLE, and exp_we outside IDLE: ignored.
//  RUN, each edge with mem_write=1 (one store per cycle, sampled on the edge):
//   - ign_en and address inside window -> ign_cnt+1; no compare.
//   - else st_addr==table[match_cnt].addr and st_data==table[match_cnt].data -> match_cnt+1;
//     if new match_cnt==latched len -> PASS.
//   - else -> FAIL code 1; capture st_addr/st_data into bad_addr/bad_data.
//  Watchdog: counts RUN cycles; when TIMEOUT_CYC!=0 and count reaches TIMEOUT_CYC-1 with no terminal event that cycle -> FAIL code 2.
//  Simultaneous events: store decision beats timeout on the same edge (final matching store -> PASS).
//   clear beats every other input; clear+start same cycle -> IDLE, start dropped.
//  Latency: outputs are registered and update on the edge that samples the event; no combinational path from inputs to outputs.
//  After PASS/FAIL further stores are ignored; counters, bad_* and fail_code hold.
//  clear: state IDLE, fail_code/match_cnt/ign_cnt/bad_* zeroed, table kept.
//  Reset asserted mid-RUN: immediate return to reset values, no pass/fail reported.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/PASS/FAIL) and fail-code constants (FC_NONE/FC_MISMATCH/FC_TIMEOUT/FC_BADLEN).
//  Sub-module exp_table: NUM_EXP x (ADDR_W+DATA_W) register file, 1 sync write port, 1 async read port
//   indexed by match_cnt, async clear on rst.
//  Top holds FSM, watchdog, counters, ignore-window compare, capture registers.
// TESTING
//  1 Load {(96,7),(100,25)}, len=2, ign off, start, stores (96,7),(100,25) -> pass=1 one edge after 2nd store, match_cnt=2.
//  2 Same table, store (100,24) first -> FAIL code 1, bad_addr=100, bad_data=24, match_cnt=0.
//  3 len=1 {(100,25)}, ign_base=96 mask=FFFFFFFC en=1, stores (96,9),(97,1),(100,25) -> PASS, ign_cnt=2.
//  4 TIMEOUT_CYC=16, start, no stores -> FAIL code 2 at RUN cycle 16; repeat with final matching store on cycle 16 -> PASS.
//  5 start with len=0 and with len=NUM_EXP+1 -> FAIL code 3 one edge later; clear -> IDLE, table intact, rerun passes.
//  6 Drop rst mid-RUN after one match -> all outputs 0 asynchronously; release, reload, start, full sequence -> PASS.

Source files
------------

// File: rtl/store_sequence_checker_pkg.sv
// Shared encodings for the store-sequence checker.
// Holds the FSM states, the fail codes and a saturating-counter helper.
package store_sequence_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef logic [1:0] fail_code_t;

  localparam fail_code_t FC_NONE     = 2'd0;
  localparam fail_code_t FC_MISMATCH = 2'd1;
  localparam fail_code_t FC_TIMEOUT  = 2'd2;
  localparam fail_code_t FC_BADLEN   = 2'd3;

  localparam logic [15:0] IGN_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == IGN_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/store_sequence_checker_exp_table.sv
// Expected-store table: one synchronous write port, one asynchronous read port.
// Out-of-range read indices return zero so the comparator never sees stale data.
module exp_table #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_EXP = 8,
  parameter int IDX_W   = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_q [NUM_EXP];
  logic [DATA_W-1:0] data_q [NUM_EXP];

  generate
    for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_entry
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] data_reg;

      // Indices at or above NUM_EXP match no entry, so such writes vanish.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          addr_reg <= '0;
          data_reg <= '0;
        end else if (we && (wr_idx == IDX_W'(gi))) begin
          addr_reg <= wr_addr;
          data_reg <= wr_data;
        end
      end

      assign addr_q[gi] = addr_reg;
      assign data_q[gi] = data_reg;
    end
  endgenerate

  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_addr = addr_q[i];
        rd_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/store_sequence_checker.sv
// Monitors the data-memory store port against a programmed (addr,data) sequence.
// Reports pass, mismatch, timeout or bad length, capturing the first offending store.
module store_sequence_checker
  import store_sequence_checker_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_EXP     = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TMO_W       = 32,
  localparam int IDX_W      = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [IDX_W-1:0]  exp_len,
  input  logic [ADDR_W-1:0] ign_base,
  input  logic [ADDR_W-1:0] ign_mask,
  input  logic              ign_en,
  input  logic              start,
  input  logic              clear,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  match_cnt,
  output logic [15:0]       ign_cnt,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] bad_data
);

  localparam bit               WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TMO_W-1:0] WD_LAST = WD_EN ? TMO_W'(TIMEOUT_CYC - 1) : '0;

  state_t            state_reg;
  logic [IDX_W-1:0]  len_reg;
  logic [TMO_W-1:0]  wd_reg;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              tbl_we;
  logic              in_win;
  logic              st_ign;
  logic              st_hit;
  logic              st_miss;
  logic              len_bad;
  logic              wd_expire;
  logic [IDX_W-1:0]  match_next;

  // Table writes are only honoured while idle, and clear suppresses them.
  assign tbl_we = exp_we && (state_reg == ST_IDLE) && !clear;

  exp_table #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_EXP (NUM_EXP),
    .IDX_W   (IDX_W)
  ) u_exp_table (
    .clk     (clk),
    .rst     (rst),
    .we      (tbl_we),
    .wr_idx  (exp_idx),
    .wr_addr (exp_addr),
    .wr_data (exp_data),
    .rd_idx  (match_cnt),
    .rd_addr (cur_addr),
    .rd_data (cur_data)
  );

  assign in_win     = ign_en && ((st_addr & ign_mask) == (ign_base & ign_mask));
  assign st_ign     = mem_write && in_win;
  assign st_hit     = mem_write && !in_win && (st_addr == cur_addr) && (st_data == cur_data);
  assign st_miss    = mem_write && !in_win && !((st_addr == cur_addr) && (st_data == cur_data));
  assign len_bad    = (exp_len == '0) || (exp_len > IDX_W'(NUM_EXP));
  assign wd_expire  = WD_EN && (wd_reg == WD_LAST);
  assign match_next = match_cnt + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      match_cnt <= '0;
      ign_cnt   <= '0;
      bad_addr  <= '0;
      bad_data  <= '0;
      len_reg   <= '0;
      wd_reg    <= '0;
    end else if (clear) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      match_cnt <= '0;
      ign_cnt   <= '0;
      bad_addr  <= '0;
      bad_data  <= '0;
      wd_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg <= exp_len;
            if (len_bad) begin
              state_reg <= ST_FAIL;
              done      <= 1'b1;
              fail_code <= FC_BADLEN;
            end else begin
              state_reg <= ST_RUN;
              busy      <= 1'b1;
              match_cnt <= '0;
              ign_cnt   <= '0;
              wd_reg    <= '0;
            end
          end
        end
        ST_RUN: begin
          if (st_ign) begin
            ign_cnt <= sat_inc16(ign_cnt);
          end
          if (st_hit) begin
            match_cnt <= match_next;
          end
          // A store decision on this edge takes priority over the watchdog.
          if (st_miss) begin
            state_reg <= ST_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_MISMATCH;
            bad_addr  <= st_addr;
            bad_data  <= st_data;
          end else if (st_hit && (match_next == len_reg)) begin
            state_reg <= ST_PASS;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b1;
          end else if (wd_expire) begin
            state_reg <= ST_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end else begin
            wd_reg <= wd_reg + TMO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
